// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding (used by both the
//               receiver and transmitter), default bit period, and the
//               frame data width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Data bits per frame
    localparam int DATA_BITS = 8;

    // Line-protocol state encoding shared by uart_rx and uart_tx.
    // WAIT_IDLE is only visited by the receiver.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_e;

    // Even parity over data plus parity bit: returns 1 when the total count
    // of ones is odd, i.e. the frame has a parity error.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                        input logic                 par);
        return (^data) ^ par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for an asynchronous, idle-high pin.
//               Both stages reset to 1 so a reset never looks like a start
//               bit. Reusable for any other idle-high pin input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,    // asynchronous, active-low
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Oversamples the rx pin with clk, validates
//               the start bit at mid-bit, shifts in 8 data bits LSB first,
//               checks the stop bit and presents each byte with a one-cycle
//               data_valid strobe qualified by frame_err.
//               Optional macro UART_RX_PARITY_EN adds an even-parity bit
//               after the data bits and a parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active-low
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT     = 3'(DATA_BITS - 1);

    // Below 8 clocks per bit the mid-bit sampling has no margin left
    if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be >= 8");
    end

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers with their next values
    // ------------------------------------------------------------------
    uart_state_e            state,      state_nxt;
    logic [CNT_W-1:0]       cnt,        cnt_nxt;
    logic [2:0]             bit_idx,    bit_idx_nxt;
    logic [DATA_BITS-1:0]   shreg,      shreg_nxt;
    logic [DATA_BITS-1:0]   data_nxt;
    logic                   valid_nxt;
    logic                   ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad,    par_bad_nxt;
    logic                   perr_nxt;
`endif

    logic cnt_half_done;
    logic cnt_bit_done;

    assign cnt_half_done = (cnt == CNT_HALF_END);
    assign cnt_bit_done  = (cnt == CNT_BIT_END);

    // State register and all datapath registers; reset aborts any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            data_out   <= data_nxt;
            data_valid <= valid_nxt;
            frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_nxt;
            parity_err <= perr_nxt;
`endif
        end
    end

    // Next-state and datapath decode; outputs hold unless a frame completes
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        data_nxt    = data_out;
        valid_nxt   = 1'b0;
        ferr_nxt    = frame_err;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = parity_err;
`endif

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            // Re-check the line half a bit in; a high level was a glitch
            START: begin
                if (cnt_half_done) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt   = IDLE;
                    end
                end
            end

            // One sample per bit period, landing on each bit centre
            DATA: begin
                if (cnt_bit_done) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_idx] = rx_s;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            // Parity result is held back until the frame completes
            PARITY: begin
                if (cnt_bit_done) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = parity_bad(shreg, rx_s);
                    state_nxt   = STOP;
                end
            end
`endif

            // Publish the byte; a low stop bit means break or bad framing
            STOP: begin
                if (cnt_bit_done) begin
                    cnt_nxt   = '0;
                    data_nxt  = shreg;
                    valid_nxt = 1'b1;
                    ferr_nxt  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_nxt  = par_bad;
`endif
                    state_nxt = rx_s ? IDLE : WAIT_IDLE;
                end
            end

            // A held-low line must go high before another start is accepted
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at CLKS_PER_BIT = 16. Frames
//               are driven on the pin; each frame posts its expected byte,
//               frame_err and completion cycle to a queue that a per-cycle
//               monitor checks the outputs against.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // Pin driven at a falling clk edge -> data_valid seen at the falling
    // edge this many cycles later (2 sync stages + 1 IDLE detect + HALF
    // + 9 bit periods).
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    int         n_pulses = 0;
    int         last_pulse = 0;
    bit         mon_en = 1'b0;
    bit         ev;
    int         n0;
    logic [7:0] abort_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hold the pin at v for n clock periods, starting and ending on a falling edge
    task automatic drive_level(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, stop level held stop_len cycles
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        exp_t e;
        e.at   = cyc + LAT;
        e.data = b;
        e.ferr = ~stop_bit;
        q.push_back(e);
        drive_level(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_level(b[i], CPB);
        drive_level(stop_bit, stop_len);
    endtask

    initial begin
        // Per-cycle monitor against the frame model
        fork
            forever begin
                @(negedge clk);
                if (rst && mon_en) begin
                    ev = (q.size() > 0) && (q[0].at == cyc);
                    check("data_valid", 32'(data_valid), 32'(ev));
                    if (data_valid) begin
                        n_pulses++;
                        last_pulse = cyc;
                    end
                    if (ev) begin
                        m_data = q[0].data;
                        m_ferr = q[0].ferr;
                        void'(q.pop_front());
                    end
                    check("data_out", 32'(data_out), 32'(m_data));
                    check("frame_err", 32'(frame_err), 32'(m_ferr));
                    if (q.size() > 0 && q[0].at < cyc) begin
                        check("missed_frame", 32'(cyc), 32'(q[0].at));
                        void'(q.pop_front());
                    end
                end
            end
        join_none

        // Reset and idle line
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h00);
        rst    = 1'b1;
        mon_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        drive_level(1'b1, 20);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(data_valid), 32'd0);
        check("idle_data_out", 32'(data_out), 32'h00);

        // Single good frame, latency pinned to 155 cycles from the pin
        n0 = cyc;
        send_frame(8'hA5, 1'b1, CPB);
        check("a5_latency", 32'(last_pulse - n0), 32'd155);
        check("a5_data_out", 32'(data_out), 32'hA5);
        check("a5_frame_err", 32'(frame_err), 32'd0);
        check("a5_busy_after", 32'(busy), 32'd0);
        check("a5_pulses", 32'(n_pulses), 32'd1);

        // Back-to-back frames, as a transmitter would send them
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        check("b2b_pulses", 32'(n_pulses), 32'd3);
        check("b2b_data_out", 32'(data_out), 32'hFF);
        check("b2b_frame_err", 32'(frame_err), 32'd0);

        // Five-cycle glitch: busy briefly, then back to IDLE without a pulse
        drive_level(1'b0, 5);
        check("glitch_busy", 32'(busy), 32'd1);
        drive_level(1'b1, 30);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_pulses", 32'(n_pulses), 32'd3);
        check("glitch_data_out", 32'(data_out), 32'hFF);

        // Low stop bit held 40 cycles: one pulse with frame_err, then wait
        send_frame(8'h3C, 1'b0, 40);
        check("brk_pulses", 32'(n_pulses), 32'd4);
        check("brk_frame_err", 32'(frame_err), 32'd1);
        check("brk_data_out", 32'(data_out), 32'h3C);
        check("brk_busy_low", 32'(busy), 32'd1);
        drive_level(1'b1, 4);
        check("brk_busy_high", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1, CPB);
        check("after_brk_data", 32'(data_out), 32'h81);
        check("after_brk_ferr", 32'(frame_err), 32'd0);
        check("after_brk_pulses", 32'(n_pulses), 32'd5);

        // Reset in the middle of data bit 4 of an 8'h5A frame
        drive_level(1'b1, 5);
        abort_byte = 8'h5A;
        drive_level(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_level(abort_byte[i], CPB);
        drive_level(abort_byte[4], HALF);
        check("abort_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_data_out", 32'(data_out), 32'h00);
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_frame_err", 32'(frame_err), 32'd0);
        m_data = 8'h00;
        m_ferr = 1'b0;
        q.delete();
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive_level(1'b1, 20);
        check("post_abort_pulses", 32'(n_pulses), 32'd5);
        send_frame(8'h5A, 1'b1, CPB);
        check("post_abort_data", 32'(data_out), 32'h5A);
        check("post_abort_ferr", 32'(frame_err), 32'd0);
        check("post_abort_pulses2", 32'(n_pulses), 32'd6);

        drive_level(1'b1, 10);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
